fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS-16 core, directly upstream of the combined instruction/data memory.
- Owns the program counter and drives the 6-bit instruction address into the memory.
- The memory returns the instruction combinationally in the same cycle; this block captures it into an IF/ID pipeline register with a valid bit.
- Supports stall, flush, branch/jump redirect, and halting on a HALT opcode or at end of program.

Parameters:
- PC_W, 6, PC / instruction-address width (64-word instruction space).
- INSTR_W, 16, instruction width.
- PROG_LEN, 18, number of loaded instruction words. Legal range 1..2^PC_W.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OP, 4'hF, opcode in instr[15:12] that halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID register.
- flush  in  1  squash IF/ID contents.
- redirect  in  1  load PC from redirect_pc (branch/jump taken).
- redirect_pc  in  PC_W  redirect target.
- imem_addr  out  PC_W  instruction address to memory; equals pc combinationally.
- imem_rd  in  INSTR_W  instruction word returned by memory (combinational).
- instr  out  INSTR_W  IF/ID instruction.
- instr_pc  out  PC_W  address of instr.
- instr_valid  out  1  instr is a real instruction.
- pc_plus1  out  PC_W  instr_pc+1 (mod 2^PC_W), registered with instr.
- halted  out  1  high while in HALT state.

Behaviour:
- States: RUN, HALT. All updates occur on posedge clk.
- Reset (synchronous, highest priority):
  - pc=RESET_PC, state=RUN.
  - instr=0, instr_pc=0, pc_plus1=0, instr_valid=0, halted=0.
  - Reset asserted mid-operation discards in-flight state in that same edge.
- Priority in RUN: reset > redirect > flush > stall > fetch.
- fetch (none of the above asserted):
  - instr<=imem_rd, instr_pc<=pc, pc_plus1<=pc+1, instr_valid<=1.
  - Latency: address presented in cycle N, instruction visible on instr from cycle N+1.
  - If imem_rd[15:12]==HALT_OP: pc holds, state<=HALT. The HALT instruction itself is delivered with valid=1.
  - Else if pc==PROG_LEN-1: pc holds, state<=HALT. The last instruction is delivered with valid=1.
  - Else pc<=pc+1.
- stall: pc, instr, instr_pc, pc_plus1 and instr_valid all hold. No fetch.
- flush: instr_valid<=0, pc holds, no fetch. The instruction at pc is fetched on the next unstalled cycle.
- redirect:
  - instr_valid<=0 (the wrong-path slot is squashed) and pc<=redirect_pc.
  - If redirect_pc>=PROG_LEN: state<=HALT. Otherwise state<=RUN.
  - redirect overrides stall and flush in the same cycle.
- HALT:
  - halted=1, registered and asserted the cycle after entry.
  - instr_valid<=0 on the first HALT cycle and stays 0; instr and instr_pc hold their last values.
  - No fetch; stall and flush are ignored.
  - Leaves only on reset (to RUN) or on redirect with redirect_pc<PROG_LEN (to RUN, halted<=0, pc<=redirect_pc).
- Arithmetic: pc+1 is PC_W wide and wraps modulo 2^PC_W, so pc_plus1 of 63 is 0. With PROG_LEN<64, pc cannot pass PROG_LEN-1 through fetch.
- imem_addr is the current pc at all times, including in HALT and during stall.

Test Plan:
- Reset, then free-run with memory words 0x1000+i and PROG_LEN=18 -> instr=0x1000..0x1011 on consecutive cycles starting 1 cycle after reset release; instr_pc=0..17. The cycle after instr_pc=17, instr_valid=0 and halted=1.
- Assert stall for 3 cycles while instr_pc=4 -> instr, instr_pc=4 and valid hold 3 cycles; imem_addr stays 5; next cycle instr_pc=5.
- At pc=6 assert redirect with redirect_pc=2 and stall both high -> next cycle instr_valid=0 and imem_addr=2; following cycle instr_pc=2 and valid=1.
- Place 0xF000 at word 7 -> delivered with instr_pc=7 and valid=1; next cycle valid=0 and halted=1. A redirect to 0 restarts fetch with instr_pc=0 one cycle later.
- Redirect to 20 (>=PROG_LEN) -> halted=1 next cycle and no valid output. A flush pulse at pc=3 -> one-cycle bubble, then instr_pc=3.
- Assert reset at instr_pc=9 with stall=1 -> next cycle instr_valid=0, halted=0, imem_addr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, captures IF/ID.
// Latency: address presented in cycle N, instruction visible on instr in cycle N+1.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall/flush; HALT ignores both.
module fetch_stage #(
   parameter int          PC_W     = 6,
   parameter int          INSTR_W  = 16,
   parameter int          PROG_LEN = 18,
   parameter int          RESET_PC = 0,
   parameter logic [3:0]  HALT_OP  = 4'hF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rd,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc_plus1,
   output logic               halted
);

   // One extra bit so PROG_LEN == 2^PC_W is representable in the bound check.
   localparam logic [PC_W:0]   LP_LEN   = (PC_W+1)'(PROG_LEN);
   localparam logic [PC_W-1:0] LP_LAST  = PC_W'(PROG_LEN - 1);
   localparam logic [PC_W-1:0] LP_RESET = PC_W'(RESET_PC);

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t               r_state;
   logic [PC_W-1:0]      r_pc;
   logic [INSTR_W-1:0]   r_instr;
   logic [PC_W-1:0]      r_instr_pc;
   logic [PC_W-1:0]      r_pc_plus1;
   logic                 r_valid;
   logic                 r_halted;

   logic [PC_W-1:0]      w_pc_inc;
   logic                 w_redir_ok;
   logic                 w_is_halt_op;
   logic                 w_at_last;

   // Next-PC arithmetic wraps modulo 2^PC_W; redirect targets outside the program halt fetch.
   assign w_pc_inc     = r_pc + PC_W'(1);
   assign w_redir_ok   = ({1'b0, redirect_pc} < LP_LEN);
   assign w_is_halt_op = (imem_rd[INSTR_W-1 -: 4] == HALT_OP);
   assign w_at_last    = (r_pc == LP_LAST);

   // PC sequencing, IF/ID capture and RUN/HALT control in one registered FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_RUN;
         r_pc       <= LP_RESET;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_pc_plus1 <= '0;
         r_valid    <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (redirect) begin
                  // Wrong-path slot is squashed; out-of-program targets enter HALT.
                  r_pc    <= redirect_pc;
                  r_valid <= 1'b0;
                  r_state <= w_redir_ok ? S_RUN : S_HALT;
               end else if (flush) begin
                  // PC holds so the squashed instruction is refetched next time.
                  r_valid <= 1'b0;
               end else if (!stall) begin
                  r_instr    <= imem_rd;
                  r_instr_pc <= r_pc;
                  r_pc_plus1 <= w_pc_inc;
                  r_valid    <= 1'b1;
                  if (w_is_halt_op || w_at_last) begin
                     // The halting / final instruction itself is still delivered.
                     r_state <= S_HALT;
                  end else begin
                     r_pc <= w_pc_inc;
                  end
               end
            end
            S_HALT: begin
               r_valid <= 1'b0;
               if (redirect && w_redir_ok) begin
                  r_pc     <= redirect_pc;
                  r_state  <= S_RUN;
                  r_halted <= 1'b0;
               end else begin
                  // halted trails state entry by one cycle.
                  r_halted <= 1'b1;
               end
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;
   assign pc_plus1    = r_pc_plus1;
   assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [5:0]  redirect_pc;
   logic [5:0]  imem_addr;
   logic [15:0] imem_rd;
   logic [15:0] instr;
   logic [5:0]  instr_pc;
   logic        instr_valid;
   logic [5:0]  pc_plus1;
   logic        halted;

   typedef struct packed {
      logic [15:0] ins;
      logic [5:0]  pc;
      logic [5:0]  pcp1;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mem [64];
   int          n_checks = 0;
   int          n_fail   = 0;

   fetch_stage #(
      .PC_W(6), .INSTR_W(16), .PROG_LEN(18), .RESET_PC(0), .HALT_OP(4'hF)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rd(imem_rd),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .pc_plus1(pc_plus1), .halted(halted)
   );

   // Combinational instruction memory.
   assign imem_rd = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // Expected IF/ID contents for one cycle in which a valid instruction will be shown.
   task automatic expect_fetch(input int pc, input logic [15:0] ins);
      exp_t e;
      e.ins  = ins;
      e.pc   = 6'(pc);
      e.pcp1 = 6'(pc + 1);
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Monitor: every cycle the DUT shows a valid instruction, pop and compare.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got pc %0d instr %0h, expected no valid output", instr_pc, instr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ifid_out", {instr, instr_pc, pc_plus1}, {e.ins, e.pc, e.pcp1});
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
      reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
      cyc(); cyc();
      chk("reset_valid",  {31'd0, instr_valid}, 32'd0);
      chk("reset_halted", {31'd0, halted},      32'd0);
      chk("reset_addr",   {26'd0, imem_addr},   32'd0);
      chk("reset_instr",  {16'd0, instr},       32'd0);
      reset = 1'b0;

      // Free run to end of program: words 0x1000..0x1011, then halt.
      for (int i = 0; i < 18; i++) begin
         expect_fetch(i, 16'h1000 + 16'(i));
         cyc();
      end
      cyc();
      chk("eop_valid",  {31'd0, instr_valid}, 32'd0);
      chk("eop_halted", {31'd0, halted},      32'd1);
      chk("eop_addr",   {26'd0, imem_addr},   32'd17);

      // Restart with a HALT opcode planted at word 7.
      mem[7] = 16'hF000;
      reset = 1'b1; cyc(); reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         expect_fetch(i, 16'h1000 + 16'(i));
         cyc();
      end
      // Stall 3 cycles while instr_pc=4: output holds, address stays 5.
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_fetch(4, 16'h1004);
         cyc();
         chk("stall_addr", {26'd0, imem_addr}, 32'd5);
      end
      stall = 1'b0;
      expect_fetch(5, 16'h1005);
      cyc();
      // pc=6: redirect to 2 together with stall.
      redirect = 1'b1; redirect_pc = 6'd2; stall = 1'b1;
      cyc();
      redirect = 1'b0; stall = 1'b0;
      chk("redir_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_addr",  {26'd0, imem_addr},   32'd2);
      for (int i = 2; i < 7; i++) begin
         expect_fetch(i, 16'h1000 + 16'(i));
         cyc();
      end
      expect_fetch(7, 16'hF000);
      cyc();
      cyc();
      chk("hop_valid",  {31'd0, instr_valid}, 32'd0);
      chk("hop_halted", {31'd0, halted},      32'd1);
      chk("hop_addr",   {26'd0, imem_addr},   32'd7);
      // Stall/flush are ignored in HALT.
      stall = 1'b1; flush = 1'b1;
      cyc();
      stall = 1'b0; flush = 1'b0;
      chk("halt_hold", {31'd0, halted}, 32'd1);
      // Redirect to 0 leaves HALT.
      redirect = 1'b1; redirect_pc = 6'd0;
      cyc();
      redirect = 1'b0;
      chk("unhalt_halted", {31'd0, halted},    32'd0);
      chk("unhalt_addr",   {26'd0, imem_addr}, 32'd0);
      expect_fetch(0, 16'h1000);
      cyc();

      // Redirect out of program (20 >= 18) halts with no valid output.
      redirect = 1'b1; redirect_pc = 6'd20;
      cyc();
      redirect = 1'b0;
      chk("oob_valid", {31'd0, instr_valid}, 32'd0);
      chk("oob_addr",  {26'd0, imem_addr},   32'd20);
      cyc();
      chk("oob_halted", {31'd0, halted},      32'd1);
      chk("oob_valid2", {31'd0, instr_valid}, 32'd0);

      // Back to 0, then a flush bubble at pc=3.
      redirect = 1'b1; redirect_pc = 6'd0;
      cyc();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_fetch(i, 16'h1000 + 16'(i));
         cyc();
      end
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_valid", {31'd0, instr_valid}, 32'd0);
      chk("flush_addr",  {26'd0, imem_addr},   32'd3);
      for (int i = 3; i < 7; i++) begin
         expect_fetch(i, 16'h1000 + 16'(i));
         cyc();
      end
      // Word 7 still holds HALT; redirect past it to 8 and run to 9.
      redirect = 1'b1; redirect_pc = 6'd8;
      cyc();
      redirect = 1'b0;
      expect_fetch(8, 16'h1008);
      cyc();
      expect_fetch(9, 16'h1009);
      cyc();

      // Reset with stall at instr_pc=9 wins.
      reset = 1'b1; stall = 1'b1;
      cyc();
      reset = 1'b0; stall = 1'b0;
      chk("mreset_valid",  {31'd0, instr_valid}, 32'd0);
      chk("mreset_halted", {31'd0, halted},      32'd0);
      chk("mreset_addr",   {26'd0, imem_addr},   32'd0);
      chk("mreset_ipc",    {26'd0, instr_pc},    32'd0);
      expect_fetch(0, 16'h1000);
      cyc();
      reset = 1'b1;
      cyc(); cyc();
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
